// File: rtl/wr_arbiter_if.sv
// Write-beat bundle shared by the upstream requesters and the downstream port.
interface wr_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              valid;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;
   logic              ready;

   modport master (output valid, addr, data, input ready);
   modport slave  (input valid, addr, data, output ready);
endinterface

// File: rtl/wr_arbiter.sv
// Two-requester round-robin write arbiter with burst locking and a single
// registered output beat.
//
// state  | meaning
// IDLE   | no grant; arbitrate among valid requesters for next cycle
// GRANT0 | requester 0 owns the output register
// GRANT1 | requester 1 owns the output register
module wr_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
) (
   input  logic         clk,
   input  logic         rst,
   wr_arbiter_if.slave  r0,
   wr_arbiter_if.slave  r1,
   wr_arbiter_if.master m,
   output logic         m_id
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   // Releasing when cnt+1 == MAX_BURST is the same as cnt == MAX_BURST-1.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] GRANT0 = 2'd1;
   localparam logic [1:0] GRANT1 = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              m_valid_q;
   logic [ADDR_W-1:0] m_addr_q;
   logic [DATA_W-1:0] m_data_q;
   logic              m_id_q;

   logic              open_slot;
   logic              rdy0, rdy1;
   logic              acc0, acc1, accept;
   logic              cur_id, cur_valid, oth_valid;

   // Output register can take a beat when empty or being drained this cycle.
   assign open_slot = ~m_valid_q | m.ready;
   assign rdy0      = (state_q == GRANT0) & open_slot;
   assign rdy1      = (state_q == GRANT1) & open_slot;
   assign r0.ready  = rdy0;
   assign r1.ready  = rdy1;

   assign acc0      = r0.valid & rdy0;
   assign acc1      = r1.valid & rdy1;
   assign accept    = acc0 | acc1;

   assign cur_id    = (state_q == GRANT1);
   assign cur_valid = cur_id ? r1.valid : r0.valid;
   assign oth_valid = cur_id ? r0.valid : r1.valid;

   assign m.valid   = m_valid_q;
   assign m.addr    = m_addr_q;
   assign m.data    = m_data_q;
   assign m_id      = m_id_q;

   // Grant sequencing, burst counting and round-robin priority.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         GRANT0, GRANT1: begin
            if (accept) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if ((accept && (cnt_q == CNT_LAST)) || !cur_valid) begin
               last_d = cur_id;
               cnt_d  = '0;
               if (oth_valid) begin
                  state_d = cur_id ? GRANT0 : GRANT1;
               end else if (cur_valid) begin
                  state_d = state_q;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            cnt_d = '0;
            if (r0.valid && (!r1.valid || last_q)) begin
               state_d = GRANT0;
            end else if (r1.valid) begin
               state_d = GRANT1;
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   // Arbitration state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // Output beat register; a held beat is dropped on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid_q <= 1'b0;
         m_addr_q  <= '0;
         m_data_q  <= '0;
         m_id_q    <= 1'b0;
      end else if (accept) begin
         m_valid_q <= 1'b1;
         m_addr_q  <= acc1 ? r1.addr : r0.addr;
         m_data_q  <= acc1 ? r1.data : r0.data;
         m_id_q    <= acc1;
      end else if (m_valid_q && m.ready) begin
         m_valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wr_arbiter.sv
// Directed bench for wr_arbiter: one instance at MAX_BURST=4, one at 1.
module tb_wr_arbiter;

   logic clk;
   logic rst;
   logic m_id_a, m_id_b;

   wr_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a0 ();
   wr_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a1 ();
   wr_arbiter_if #(.ADDR_W(32), .DATA_W(32)) am ();
   wr_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
   wr_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
   wr_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bm ();

   wr_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
      .clk (clk), .rst (rst), .r0 (a0), .r1 (a1), .m (am), .m_id (m_id_a)
   );

   wr_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(1)) dut1 (
      .clk (clk), .rst (rst), .r0 (b0), .r1 (b1), .m (bm), .m_id (m_id_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Source models: beats remaining and next address per requester.
   int          s0_n, s1_n, sb0_n, sb1_n;
   logic [31:0] s0_a, s1_a, sb0_a, sb1_a;
   logic        mr_a, mr_b;

   logic [64:0] log_a[$];
   logic [64:0] log_b[$];
   logic [64:0] exp_q[$];

   function automatic logic [31:0] dat(input logic [31:0] a);
      return a ^ 32'hDA7A_0000;
   endfunction

   function automatic logic [64:0] mk(input logic id, input logic [31:0] a);
      return {id, a, dat(a)};
   endfunction

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic drive();
      a0.valid = (s0_n > 0);  a0.addr = s0_a;  a0.data = dat(s0_a);
      a1.valid = (s1_n > 0);  a1.addr = s1_a;  a1.data = dat(s1_a);
      b0.valid = (sb0_n > 0); b0.addr = sb0_a; b0.data = dat(sb0_a);
      b1.valid = (sb1_n > 0); b1.addr = sb1_a; b1.data = dat(sb1_a);
      am.ready = mr_a;
      bm.ready = mr_b;
   endtask

   task automatic settle();
      drive();
      #1;
   endtask

   // Advance one clock; called at the mid-cycle sample point.
   task automatic tick();
      logic t0, t1, tb0, tb1;
      t0  = a0.valid & a0.ready;
      t1  = a1.valid & a1.ready;
      tb0 = b0.valid & b0.ready;
      tb1 = b1.valid & b1.ready;
      if (am.valid && am.ready) log_a.push_back({m_id_a, am.addr, am.data});
      if (bm.valid && bm.ready) log_b.push_back({m_id_b, bm.addr, bm.data});
      @(posedge clk);
      if (t0)  begin s0_n--;  s0_a++;  end
      if (t1)  begin s1_n--;  s1_a++;  end
      if (tb0) begin sb0_n--; sb0_a++; end
      if (tb1) begin sb1_n--; sb1_a++; end
      #1;
      drive();
      #1;
   endtask

   task automatic cmp_log(input string tag, input logic [64:0] got[$], input logic [64:0] expv[$]);
      chk({tag, "_len"}, 65'(got.size()), 65'(expv.size()));
      for (int i = 0; i < expv.size(); i++) begin
         if (i < got.size()) chk($sformatf("%s[%0d]", tag, i), got[i], expv[i]);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_m_valid"}, 65'(am.valid), 65'(0));
      chk({tag, "_m_addr"},  65'(am.addr),  65'(0));
      chk({tag, "_m_data"},  65'(am.data),  65'(0));
      chk({tag, "_m_id"},    65'(m_id_a),   65'(0));
      chk({tag, "_r0_ready"}, 65'(a0.ready), 65'(0));
      chk({tag, "_r1_ready"}, 65'(a1.ready), 65'(0));
      chk({tag, "_b_valid"}, 65'(bm.valid), 65'(0));
   endtask

   initial begin
      logic e;
      int   n0, n1;

      // Reset with both requesters valid.
      rst = 1'b1;
      s0_n = 2;  s0_a = 32'h100; s1_n = 2;  s1_a = 32'h200;
      sb0_n = 0; sb0_a = 32'h0;  sb1_n = 0; sb1_a = 32'h0;
      mr_a = 1'b1; mr_b = 1'b1;
      settle();
      tick(); chk_reset("rst_c1");
      tick(); chk_reset("rst_c2");
      rst = 1'b0;
      settle();
      chk("post_rst_idle_r0_ready", 65'(a0.ready), 65'(0));
      tick();
      chk("first_grant_r0_ready", 65'(a0.ready), 65'(1));
      chk("first_grant_r1_ready", 65'(a1.ready), 65'(0));
      tick();
      chk("first_m_valid", 65'(am.valid), 65'(1));
      chk("first_m_id",    65'(m_id_a),   65'(0));
      chk("first_m_addr",  65'(am.addr),  65'(32'h100));
      repeat (8) tick();
      exp_q = {mk(0, 32'h100), mk(0, 32'h101), mk(1, 32'h200), mk(1, 32'h201)};
      cmp_log("rst_log", log_a, exp_q);
      log_a.delete();

      // Single stream of 6 beats from R0 through a burst-4 re-grant.
      s0_n = 6; s0_a = 32'h10;
      settle();
      chk("single_idle_ready", 65'(a0.ready), 65'(0));
      tick();
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("single_ready[%0d]", i), 65'(a0.ready), 65'(1));
         if (i > 0) begin
            chk($sformatf("single_addr[%0d]", i), 65'(am.addr), 65'(32'h10 + i - 1));
            chk($sformatf("single_id[%0d]", i),   65'(m_id_a),  65'(0));
         end
         tick();
      end
      chk("single_last_addr",  65'(am.addr),  65'(32'h15));
      chk("single_last_valid", 65'(am.valid), 65'(1));
      repeat (3) tick();
      exp_q.delete();
      for (int i = 0; i < 6; i++) exp_q.push_back(mk(0, 32'h10 + i));
      cmp_log("single_log", log_a, exp_q);
      log_a.delete();

      // Contention: R0 was released last, so R1 leads the rotation.
      s0_n = 12; s0_a = 32'h300; s1_n = 12; s1_a = 32'h400;
      settle();
      chk("cont_idle_r0", 65'(a0.ready), 65'(0));
      chk("cont_idle_r1", 65'(a1.ready), 65'(0));
      tick();
      exp_q.delete();
      n0 = 0; n1 = 0;
      for (int k = 0; k < 24; k++) begin
         e = ((k / 4) % 2 == 0);
         chk($sformatf("cont_r1_ready[%0d]", k), 65'(a1.ready), 65'(e));
         chk($sformatf("cont_r0_ready[%0d]", k), 65'(a0.ready), 65'(!e));
         if (e) begin exp_q.push_back(mk(1, 32'h400 + n1)); n1++; end
         else   begin exp_q.push_back(mk(0, 32'h300 + n0)); n0++; end
         tick();
      end
      repeat (4) tick();
      cmp_log("cont_log", log_a, exp_q);
      log_a.delete();

      // Backpressure with beat 0x20 held in the output register.
      s0_n = 3; s0_a = 32'h20; mr_a = 1'b1;
      settle();
      tick();
      chk("bp_pre_ready", 65'(a0.ready), 65'(1));
      mr_a = 1'b0;
      settle();
      tick();
      for (int j = 0; j < 3; j++) begin
         chk($sformatf("bp_valid[%0d]", j), 65'(am.valid), 65'(1));
         chk($sformatf("bp_addr[%0d]", j),  65'(am.addr),  65'(32'h20));
         chk($sformatf("bp_data[%0d]", j),  65'(am.data),  65'(dat(32'h20)));
         chk($sformatf("bp_id[%0d]", j),    65'(m_id_a),   65'(0));
         chk($sformatf("bp_ready[%0d]", j), 65'(a0.ready), 65'(0));
         tick();
      end
      mr_a = 1'b1;
      settle();
      chk("bp_release_ready", 65'(a0.ready), 65'(1));
      chk("bp_release_addr",  65'(am.addr),  65'(32'h20));
      repeat (5) tick();
      exp_q = {mk(0, 32'h20), mk(0, 32'h21), mk(0, 32'h22)};
      cmp_log("bp_log", log_a, exp_q);
      log_a.delete();

      // MAX_BURST=1 instance alternates every beat.
      sb0_n = 3; sb0_a = 32'h500; sb1_n = 3; sb1_a = 32'h600;
      settle();
      repeat (10) tick();
      exp_q = {mk(0, 32'h500), mk(1, 32'h600), mk(0, 32'h501),
               mk(1, 32'h601), mk(0, 32'h502), mk(1, 32'h602)};
      cmp_log("mb1_log", log_b, exp_q);

      // Reset in the middle of a GRANT1 burst.
      s1_n = 4; s1_a = 32'h700;
      settle();
      tick();
      chk("mid_g1_ready", 65'(a1.ready), 65'(1));
      tick();
      tick();
      chk("mid_held_valid", 65'(am.valid), 65'(1));
      chk("mid_held_addr",  65'(am.addr),  65'(32'h701));
      rst = 1'b1;
      s0_n = 2; s0_a = 32'h800;
      settle();
      tick();
      chk("mid_rst_m_valid",  65'(am.valid), 65'(0));
      chk("mid_rst_r0_ready", 65'(a0.ready), 65'(0));
      chk("mid_rst_r1_ready", 65'(a1.ready), 65'(0));
      rst = 1'b0;
      settle();
      chk("mid_idle_r1_ready", 65'(a1.ready), 65'(0));
      tick();
      chk("mid_regrant_r0", 65'(a0.ready), 65'(1));
      chk("mid_regrant_r1", 65'(a1.ready), 65'(0));
      tick();
      chk("mid_first_id",   65'(m_id_a),  65'(0));
      chk("mid_first_addr", 65'(am.addr), 65'(32'h800));
      chk("mid_first_data", 65'(am.data), 65'(dat(32'h800)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
